mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage. It sits beside the ALU and takes the same A/B operands from the register-file read ports.
- It owns the architectural HI/LO registers for mult, multu, div, divu, mthi and mtlo. mfhi/mflo read HI/LO directly.
- The controller stalls issue while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle op request, sampled on the rising edge.
- MDUOp  input  3  000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo, 11x reserved (no-op).
- A  input  WIDTH  rs operand; dividend / multiplicand / mthi-mtlo source.
- B  input  WIDTH  rt operand; divisor / multiplier.
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.
- busy  output  1  high while a multiply/divide is in progress.

Behaviour:
- Reset (reset_n low, asynchronous): HI=0, LO=0, busy=0, FSM=IDLE, counter=0. Reset mid-operation aborts it; no partial result is written.
- FSM states:
  - IDLE, MUL, DIV, DONE.
- IDLE:
  - On an edge with start=1:
    - MDUOp 000/001 -> MUL.
    - 010/011 -> DIV.
    - 100 -> HI<=A at that edge, stay IDLE, busy stays 0.
    - 101 -> LO<=A likewise.
    - 11x -> ignored.
  - On entry to MUL/DIV, latch |A| and |B|, the signs (signed ops only; unsigned ops treat operands as magnitudes), and the op. Clear the accumulator and set counter=0. busy=1 from this edge.
- MUL:
  - Radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH-bit accumulator.
  - WIDTH iterations, then go to DONE.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - Per cycle: remainder shifts left and takes the next dividend bit; subtract the divisor if no borrow; the quotient bit is the inverted borrow.
  - WIDTH iterations, then go to DONE.
- DONE (one cycle):
  - Apply sign fix-up and write HI/LO, busy<=0, return to IDLE.
  - Total: start edge E0; HI/LO and busy=0 update at edge E(WIDTH+1). busy is high for exactly WIDTH+1 cycles (33 at default).
- Results:
  - mult/multu: {HI,LO} = 64-bit product. Signed: negate the product if the sign bits differ.
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Signed overflow (-2^31 / -1): LO=0x80000000, HI=0 (natural wrap).
  - Divide by zero (any div op): completes with normal latency, LO=0xFFFFFFFF, HI=A as latched.
- While busy:
  - start is ignored for every MDUOp, including mthi/mtlo.
  - HI/LO hold their previous values until DONE.
  - Operand changes on A/B have no effect after E0.
- start on the same edge that busy falls (DONE edge): not accepted. busy is still high during that cycle; the controller re-presents start on the next cycle.
- HI/LO change only at DONE, mthi/mtlo, or reset.

Test Plan:
- Unsigned multiply: reset, multu A=0xFFFFFFFF B=0xFFFFFFFF -> busy high exactly 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply: mult A=0xFFFFFFFD (-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Signed divide and overflow:
  - div A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: divu A=100 B=0 -> after 33 cycles HI=100, LO=0xFFFFFFFF. Then divu 100/7 -> LO=14, HI=2.
- Ignored requests while busy:
  - mthi A=0x1234 while idle -> HI=0x1234 next edge, busy stays 0.
  - Start multu 2*3, then during busy pulse mtlo A=0xDEAD and change A/B -> final LO=6, HI=0, mtlo ignored.
- Reset mid-operation: start divu 50/5, deassert reset_n at cycle 10 (asynchronous, mid-cycle) -> HI=LO=0 and busy=0 immediately. After release, a new multu 4*4 gives LO=16 with full latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (mult/multu/div/divu/mthi/mtlo).
// Latency: mul/div results and busy=0 appear WIDTH+1 edges after the accepting start edge; mthi/mtlo write on the start edge.
// Backpressure: busy is high while an operation runs; any start seen while busy (including the DONE edge) is dropped.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_mag, b_mag, a_raw;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q, neg_r, is_div, div_zero;

    logic               op_signed, accept_mul, accept_div, last_iter;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff, div_rem;
    logic               div_borrow;
    logic [WIDTH-1:0]   quo, rem;

    // Odd opcodes of the mul/div group are the signed variants.
    assign op_signed  = MDUOp[0];
    assign a_abs      = (op_signed && A[WIDTH-1]) ? -A : A;
    assign b_abs      = (op_signed && B[WIDTH-1]) ? -B : B;
    assign accept_mul = (state == IDLE) && start && (MDUOp[2:1] == 2'b00);
    assign accept_div = (state == IDLE) && start && (MDUOp[2:1] == 2'b01);
    assign last_iter  = (cnt == CNT_W'(WIDTH - 1));
    assign busy       = (state != IDLE);

    // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
    assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : {WIDTH{1'b0}})};

    // Restoring step: high half is the remainder, low half shifts dividend bits out and quotient bits in.
    assign div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_borrow = (div_shift < {1'b0, b_mag});
    assign div_diff   = div_shift[WIDTH-1:0] - b_mag;
    assign div_rem    = div_borrow ? div_shift[WIDTH-1:0] : div_diff;

    assign quo        = acc[WIDTH-1:0];
    assign rem        = acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: run WIDTH iterations, then one fix-up/writeback cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_mul)      state_nxt = MUL;
                else if (accept_div) state_nxt = DIV;
            end
            MUL:     if (last_iter) state_nxt = DONE;
            DIV:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on acceptance and one iteration per cycle afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_mul || accept_div) begin
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        a_raw    <= A;
                        neg_q    <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_r    <= op_signed & A[WIDTH-1];
                        is_div   <= accept_div;
                        div_zero <= (B == '0);
                        cnt      <= '0;
                        acc      <= {{WIDTH{1'b0}}, (accept_mul ? b_abs : a_abs)};
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    cnt <= cnt + CNT_W'(1);
                end
                DIV: begin
                    acc <= {div_rem, acc[WIDTH-2:0], ~div_borrow};
                    cnt <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // HI/LO: sign-corrected result at DONE, direct moves from A when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            HI <= '0;
            LO <= '0;
        end else if (state == DONE) begin
            if (is_div) begin
                if (div_zero) begin
                    HI <= a_raw;
                    LO <= '1;
                end else begin
                    HI <= neg_r ? -rem : rem;
                    LO <= neg_q ? -quo : quo;
                end
            end else begin
                {HI, LO} <= neg_q ? -acc : acc;
            end
        end else if (state == IDLE && start) begin
            if (MDUOp == 3'b100) HI <= A;
            if (MDUOp == 3'b101) LO <= A;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    MDUOp = 3'd0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [W-1:0]  HI, LO;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural HI/LO plus cycles left on the pending op.
    logic [W-1:0]  m_hi = '0;
    logic [W-1:0]  m_lo = '0;
    int            m_cnt = 0;
    logic [63:0]   m_res = '0;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .MDUOp   (MDUOp),
        .A       (A),
        .B       (B),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI,LO} computed with plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return ua * ub;
            3'd1: return 64'(sa * sb);
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 3'd2) return {32'(ua % ub), 32'(ua / ub)};
                q = sa / sb;
                r = sa % sb;
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    // Model: an accepted mul/div completes W+1 edges later; starts while pending are dropped.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi  = '0;
            m_lo  = '0;
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = m_res[63:32];
                m_lo = m_res[31:0];
            end
        end else if (start) begin
            if (MDUOp <= 3'd3) begin
                m_res = ref_result(MDUOp, A, B);
                m_cnt = W + 1;
            end else if (MDUOp == 3'd4) begin
                m_hi = A;
            end else if (MDUOp == 3'd5) begin
                m_lo = A;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_hi", 64'(HI), 64'(m_hi));
        chk("cyc_lo", 64'(LO), 64'(m_lo));
        chk("cyc_busy", 64'(busy), 64'(m_cnt > 0));
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op; n returns how many sampled cycles busy stayed high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int n);
        @(negedge clk);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("busy_timeout", 64'(n), 64'd0);
    endtask

    initial begin
        int n;

        // Pin the reference model with hand-computed values.
        chk("ref_multu", ref_result(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("ref_mult",  ref_result(3'd1, 32'hFFFF_FFFD, 32'd5),         64'hFFFF_FFFF_FFFF_FFF1);
        chk("ref_div",   ref_result(3'd3, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_ovf",   ref_result(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        chk("ref_div0",  ref_result(3'd2, 32'd100, 32'd0),               64'h0000_0064_FFFF_FFFF);

        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_lat", 64'(n), 64'd33);
        chk("multu_hi", 64'(HI), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(LO), 64'h0000_0001);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, n);
        chk("mult_hi", 64'(HI), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(LO), 64'hFFFF_FFF1);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
        chk("div_lo", 64'(LO), 64'hFFFF_FFFD);
        chk("div_hi", 64'(HI), 64'hFFFF_FFFF);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("ovf_lo", 64'(LO), 64'h8000_0000);
        chk("ovf_hi", 64'(HI), 64'd0);

        run_op(3'd2, 32'd100, 32'd0, n);
        chk("div0_lat", 64'(n), 64'd33);
        chk("div0_hi", 64'(HI), 64'd100);
        chk("div0_lo", 64'(LO), 64'hFFFF_FFFF);

        run_op(3'd2, 32'd100, 32'd7, n);
        chk("divu_lo", 64'(LO), 64'd14);
        chk("divu_hi", 64'(HI), 64'd2);

        run_op(3'd4, 32'h1234, 32'd0, n);
        chk("mthi_busy", 64'(n), 64'd0);
        chk("mthi_hi", 64'(HI), 64'h1234);

        // mtlo and operand changes while a multiply is running must have no effect.
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd0; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        repeat (5) @(negedge clk);
        start = 1'b1; MDUOp = 3'd5; A = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("ign_wait", 64'(n < 200), 64'd1);
        chk("ign_lo", 64'(LO), 64'd6);
        chk("ign_hi", 64'(HI), 64'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; MDUOp = 3'd2; A = 32'd50; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_hi", 64'(HI), 64'd0);
        chk("arst_lo", 64'(LO), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        run_op(3'd0, 32'd4, 32'd4, n);
        chk("post_rst_lat", 64'(n), 64'd33);
        chk("post_rst_lo", 64'(LO), 64'd16);
        chk("post_rst_hi", 64'(HI), 64'd0);

        // Random traffic, including starts while busy and on the DONE edge.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                MDUOp = 3'($urandom_range(0, 7));
                A = pick();
                B = pick();
            end else begin
                start = 1'b0;
                A = $urandom;
                B = $urandom;
            end
        end
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("final_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
